// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-ported memory (fetch + data).
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RSP_IF,
        RSP_D
    } rsp_state_t;

    rsp_state_t rsp_state;
    logic       force_if;
    logic       if_gnt;
    logic       d_gnt;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    // Count data grants that overtook a waiting fetch; saturate at LIMIT.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            starve_cnt <= '0;
        end else if (!i_if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_if = i_if_req && (starve_cnt == LIMIT);
`else
    logic [3:0] unused_limit;

    assign unused_limit = 4'(STARVE_LIMIT);
    assign force_if     = 1'b0;
`endif

    // Data wins unless the guard forces fetch; nothing granted in reset.
    always_comb begin
        d_gnt  = !i_reset && i_d_req && !force_if;
        if_gnt = !i_reset && i_if_req && !d_gnt;
    end

    assign o_if_gnt = if_gnt;
    assign o_d_gnt  = d_gnt;

    // The granted requester owns the memory port in the same cycle.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        if (d_gnt) begin
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
            o_mem_read  = !i_d_we;
            o_mem_write = i_d_we;
        end else if (if_gnt) begin
            o_mem_addr = i_if_addr;
            o_mem_read = 1'b1;
        end
    end

    // Remember who owns the read data returning next cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rsp_state <= IDLE;
        end else if (if_gnt) begin
            rsp_state <= RSP_IF;
        end else if (d_gnt && !i_d_we) begin
            rsp_state <= RSP_D;
        end else begin
            rsp_state <= IDLE;
        end
    end

    // Route returning data to its owner; the other side sees zero.
    always_comb begin
        o_if_rvalid = !i_reset && (rsp_state == RSP_IF);
        o_d_rvalid  = !i_reset && (rsp_state == RSP_D);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_d_rdata   = o_d_rvalid ? i_mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus contention/reset sequences.
// Honours ARB_STARVE_GUARD_EN the same way the design does.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 3;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_if_req(if_req),
        .i_if_addr(if_addr),
        .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid),
        .o_if_rdata(if_rdata),
        .i_d_req(d_req),
        .i_d_we(d_we),
        .i_d_addr(d_addr),
        .i_d_wdata(d_wdata),
        .o_d_gnt(d_gnt),
        .o_d_rvalid(d_rvalid),
        .o_d_rdata(d_rdata),
        .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_read(mem_read),
        .o_mem_write(mem_write),
        .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: registered read, one cycle latency.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        bit            rst;
        bit            if_req;
        logic [AW-1:0] if_addr;
        bit            d_req;
        bit            d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        bit            e_if;
        bit            e_d;
    } vec_t;

    typedef struct {
        int            due;
        bit            is_if;
        logic [DW-1:0] data;
    } rsp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            mcnt = 0;
    int            n_if_gnt = 0;
    logic [DW-1:0] ref_mem [256];
    rsp_t          sb [$];
    vec_t          tbl [$];

    function automatic logic [DW-1:0] pat(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {8'hC3, b, ~b, b ^ 8'h5A};
    endfunction

    function automatic vec_t mk(input bit r, input bit ir, input int ia,
                                input bit dr, input bit we, input int da,
                                input logic [DW-1:0] wd,
                                input bit ei, input bit ed);
        vec_t v;
        v.rst = r; v.if_req = ir; v.if_addr = 8'(ia);
        v.d_req = dr; v.d_we = we; v.d_addr = 8'(da); v.d_wdata = wd;
        v.e_if = ei; v.e_d = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h",
                     name, cyc, act, exp);
        end
    endtask

    // One clock: drive, check at negedge against the reference, advance.
    task automatic step(input vec_t v);
        rsp_t          r;
        bit            x_ifv;
        bit            x_dv;
        logic [DW-1:0] x_dat;
        bit            force_if;
        bit            eg_d;
        bit            eg_if;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wdata;
        rst = v.rst; if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr;
        d_wdata = v.d_wdata;
        @(negedge clk);
        if (v.rst) sb.delete();
        x_ifv = 1'b0; x_dv = 1'b0; x_dat = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            x_ifv = r.is_if;
            x_dv = !r.is_if;
            x_dat = r.data;
        end
        chk("if_rvalid", 32'(if_rvalid), 32'(x_ifv));
        chk("d_rvalid", 32'(d_rvalid), 32'(x_dv));
        chk("if_rdata", if_rdata, x_ifv ? x_dat : '0);
        chk("d_rdata", d_rdata, x_dv ? x_dat : '0);
        force_if = GUARD && v.if_req && (mcnt == LIMIT);
        eg_d = !v.rst && v.d_req && !force_if;
        eg_if = !v.rst && v.if_req && (!v.d_req || force_if);
        x_addr = eg_d ? v.d_addr : (eg_if ? v.if_addr : '0);
        x_wdata = eg_d ? v.d_wdata : '0;
        chk("if_gnt", 32'(if_gnt), 32'(eg_if));
        chk("d_gnt", 32'(d_gnt), 32'(eg_d));
        chk("mem_read", 32'(mem_read), 32'(eg_if || (eg_d && !v.d_we)));
        chk("mem_write", 32'(mem_write), 32'(eg_d && v.d_we));
        chk("mem_addr", 32'(mem_addr), 32'(x_addr));
        chk("mem_wdata", mem_wdata, x_wdata);
        if (if_gnt) n_if_gnt++;
        if (eg_if) sb.push_back('{cyc + 1, 1'b1, ref_mem[v.if_addr]});
        if (eg_d && !v.d_we) sb.push_back('{cyc + 1, 1'b0, ref_mem[v.d_addr]});
        if (eg_d && v.d_we) ref_mem[v.d_addr] = v.d_wdata;
        if (v.rst || !v.if_req || eg_if) mcnt = 0;
        else if (eg_d && mcnt < LIMIT) mcnt++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running expected=done", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int exp_if;
        for (int i = 0; i < 256; i++) begin
            mem[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        mem_rdata = '0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        @(posedge clk);
        #1;

        tbl.push_back(mk(1, 1, 'h04, 1, 0, 'h08, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h04, 0, 0, 'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 1, 1, 'h10, 32'hDEADBEEF, 0, 1));
        tbl.push_back(mk(0, 0, 'h00, 1, 0, 'h10, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h08, 1, 0, 'h20, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h08, 0, 0, 'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h0C, 1, 0, 'h10, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h0C, 0, 0, 'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 'h00, 1, 1, 'h30, 32'h55AA55AA, 0, 1));
        tbl.push_back(mk(0, 0, 'h00, 1, 0, 'h30, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h20, 0, 0, 'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 'h00, 1, 0, 'h04, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 'h00, 1, 0, 'h08, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h40, 1, 0, 'h44, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'h40, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            checks++;
            if (if_gnt !== 1'b0 && i == 0) begin
                errors++;
                $display("FAIL pre_reset_gnt actual=%b expected=0", if_gnt);
            end
            step(tbl[i]);
        end

        // Direct constant checks on table results.
        chk("mem10_written", mem[8'h10], 32'hDEADBEEF);
        chk("mem30_written", mem[8'h30], 32'h55AA55AA);

        // Continuous contention: fetch waits against back-to-back loads.
        base = n_if_gnt;
        for (int i = 0; i < 12; i++)
            step(mk(0, 1, 'h14, 1, 0, 8'(8'h50 + i), 0, 0, 0));
        exp_if = GUARD ? 3 : 0;
        chk("contention_if_gnts", 32'(n_if_gnt - base), 32'(exp_if));
        step(mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0));
        step(mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0));

        // Reset right after a fetch grant must swallow the response.
        step(mk(0, 1, 'h04, 0, 0, 'h00, 0, 1, 0));
        step(mk(1, 0, 'h00, 0, 0, 'h00, 0, 0, 0));
        step(mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0));
        chk("post_reset_no_rvalid", 32'(if_rvalid | d_rvalid), 32'd0);
        step(mk(0, 1, 'h04, 0, 0, 'h00, 0, 1, 0));
        step(mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0));
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 8: memory address width in bits.
REQ-002 Parameter DATA_W, 32: memory data width in bits.
REQ-003 Parameter STARVE_LIMIT, 3: maximum consecutive data grants while fetch waits; range 1..15.
REQ-004 i_clk  in  1  clock; all state updates on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_if_req  in  1  instruction-fetch read request; held with i_if_addr stable until o_if_gnt.
REQ-007 i_if_addr  in  ADDR_W  fetch address.
REQ-008 o_if_gnt  out  1  fetch request accepted this cycle.
REQ-009 o_if_rvalid  out  1  fetch read data valid.
REQ-010 o_if_rdata  out  DATA_W  fetch read data.
REQ-011 i_d_req  in  1  data request; held with address, we and wdata stable until o_d_gnt.
REQ-012 i_d_we  in  1  1 = write, 0 = read.
REQ-013 i_d_addr  in  ADDR_W  data address.
REQ-014 i_d_wdata  in  DATA_W  store data.
REQ-015 o_d_gnt  out  1  data request accepted this cycle.
REQ-016 o_d_rvalid  out  1  load data valid.
REQ-017 o_d_rdata  out  DATA_W  load data.
REQ-018 o_mem_addr  out  ADDR_W  shared memory address.
REQ-019 o_mem_wdata  out  DATA_W  shared memory write data.
REQ-020 o_mem_read  out  1  memory read enable.
REQ-021 o_mem_write  out  1  memory write enable.
REQ-022 i_mem_rdata  in  DATA_W  memory read data, registered, valid one cycle after o_mem_read.

Function
REQ-023 Grants are combinational from current requests and state; at most one of o_if_gnt/o_d_gnt high per cycle.
REQ-024 Default policy: data has priority; fetch granted only when i_d_req low, or when the starvation guard forces it (REQ-036).
REQ-025 Granted requester drives the memory port the same cycle: o_mem_addr, o_mem_wdata (data only, else 0), o_mem_read = gnt & !write, o_mem_write = o_d_gnt & i_d_we.
REQ-026 No grant: o_mem_read = o_mem_write = 0, o_mem_addr = 0, o_mem_wdata = 0.
REQ-027 Response tracker register rsp_state: IDLE, RSP_IF, RSP_D; next state RSP_IF on fetch grant, RSP_D on data read grant, otherwise IDLE (including data write grants).
REQ-028 In RSP_IF: o_if_rvalid = 1, o_if_rdata = i_mem_rdata; in RSP_D: o_d_rvalid = 1, o_d_rdata = i_mem_rdata; rdata of the non-owner is 0.
REQ-029 Read latency: rvalid exactly one cycle after the granting cycle; back-to-back grants give rvalid on consecutive cycles, one per grant, in grant order.
REQ-030 Writes never produce rvalid.
REQ-031 Requests arriving together: data wins unless REQ-036 applies; the loser stays pending with no grant.
REQ-032 Deasserting a request before grant is allowed; it is silently dropped.

Reset
REQ-033 While i_reset high: rsp_state = IDLE, starvation counter = 0, o_if_rvalid = o_d_rvalid = 0, both rdata = 0, both gnt = 0, o_mem_read = o_mem_write = 0.
REQ-034 Reset during a pending read discards the response: no rvalid in the cycle after reset deasserts, regardless of i_mem_rdata.

Configuration
REQ-035 Macro ARB_STARVE_GUARD_EN enables the fetch starvation guard.
REQ-036 Defined: a 4-bit counter increments on each data grant while i_if_req is high and saturates at STARVE_LIMIT; while counter == STARVE_LIMIT and i_if_req high, fetch is granted over data; counter clears on fetch grant or when i_if_req is low.
REQ-037 Not defined: no counter is instantiated; strict data priority; fetch may starve indefinitely.

Verification
REQ-038 Fetch only, addr 0x04 -> o_if_gnt=1 same cycle, o_mem_read=1, o_if_rvalid=1 next cycle with rdata = mem[0x04].
REQ-039 Data write addr 0x10 wdata 0xDEADBEEF, then data read addr 0x10 -> o_mem_write pulses once, no rvalid for the write, o_d_rdata=0xDEADBEEF one cycle after the read grant.
REQ-040 Fetch and data read both requesting continuously, guard off -> o_d_gnt every cycle, o_if_gnt never.
REQ-041 Same stimulus, ARB_STARVE_GUARD_EN defined, STARVE_LIMIT=3 -> grant pattern D,D,D,IF repeating; each rvalid routed to its owner.
REQ-042 Fetch read granted, i_reset high next cycle -> o_if_rvalid stays 0 through and after reset; first post-reset grant behaves as REQ-038.
REQ-043 Alternating IF/D read grants on consecutive cycles -> rvalids alternate on following cycles with correct owner and data.
